// File: rtl/pixel_mode_proc.sv
// rtl/pixel_mode_proc.sv - 3-stage per-frame pixel mode processor (pass/invert/gray/binary)
// Mode and threshold are latched on a VSYNC rise and ride the pipeline with each pixel.
module pixel_mode_proc #(
    parameter int CW     = 8,
    parameter int FCNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_VDE,
    input  logic              i_HSYNC,
    input  logic              i_VSYNC,
    input  logic [3*CW-1:0]   i_pixelData,
    input  logic [1:0]        i_mode,
    input  logic [CW-1:0]     i_thresh,
    output logic              o_VDE,
    output logic              o_HSYNC,
    output logic              o_VSYNC,
    output logic [3*CW-1:0]   o_pixelData,
    output logic [1:0]        o_modeActive,
    output logic [FCNT_W-1:0] o_frameCnt
);

    localparam int SW = CW + 10;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_BIN  = 2'd3;

    logic [1:0]        mode_act_q, mode_act_d;
    logic [CW-1:0]     thr_act_q,  thr_act_d;
    logic [FCNT_W-1:0] fcnt_q,     fcnt_d;

    logic              s1_vde_q,  s1_vde_d;
    logic              s1_hs_q,   s1_hs_d;
    logic              s1_vs_q,   s1_vs_d;
    logic [3*CW-1:0]   s1_pix_q,  s1_pix_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [CW-1:0]     s1_thr_q,  s1_thr_d;

    logic              s2_vde_q,  s2_vde_d;
    logic              s2_hs_q,   s2_hs_d;
    logic              s2_vs_q,   s2_vs_d;
    logic [3*CW-1:0]   s2_pix_q,  s2_pix_d;
    logic [1:0]        s2_mode_q, s2_mode_d;
    logic [CW-1:0]     s2_thr_q,  s2_thr_d;
    logic [CW-1:0]     s2_y_q,    s2_y_d;

    logic              s3_vde_q,  s3_vde_d;
    logic              s3_hs_q,   s3_hs_d;
    logic              s3_vs_q,   s3_vs_d;
    logic [3*CW-1:0]   s3_pix_q,  s3_pix_d;

    logic              vs_rise;
    logic [SW-1:0]     luma_sum;
    logic [3*CW-1:0]   mode_pix;

    always_comb begin
        // s1_vs_q doubles as the registered VSYNC used for edge detection
        vs_rise    = i_VSYNC & ~s1_vs_q;
        mode_act_d = vs_rise ? i_mode   : mode_act_q;
        thr_act_d  = vs_rise ? i_thresh : thr_act_q;
        fcnt_d     = vs_rise ? fcnt_q + FCNT_W'(1) : fcnt_q;

        s1_vde_d  = i_VDE;
        s1_hs_d   = i_HSYNC;
        s1_vs_d   = i_VSYNC;
        s1_pix_d  = i_pixelData;
        s1_mode_d = mode_act_q;
        s1_thr_d  = thr_act_q;

        luma_sum = SW'(s1_pix_q[3*CW-1:2*CW]) * SW'(77)
                 + SW'(s1_pix_q[2*CW-1:CW])   * SW'(150)
                 + SW'(s1_pix_q[CW-1:0])      * SW'(29);

        s2_vde_d  = s1_vde_q;
        s2_hs_d   = s1_hs_q;
        s2_vs_d   = s1_vs_q;
        s2_pix_d  = s1_pix_q;
        s2_mode_d = s1_mode_q;
        s2_thr_d  = s1_thr_q;
        s2_y_d    = CW'(luma_sum >> 8);

        mode_pix = s2_pix_q;
        case (s2_mode_q)
            MODE_PASS: mode_pix = s2_pix_q;
            MODE_INV:  mode_pix = ~s2_pix_q;
            MODE_GRAY: mode_pix = {3{s2_y_q}};
            MODE_BIN:  mode_pix = (s2_y_q >= s2_thr_q) ? {3*CW{1'b1}} : {3*CW{1'b0}};
            default:   mode_pix = s2_pix_q;
        endcase

        s3_vde_d = s2_vde_q;
        s3_hs_d  = s2_hs_q;
        s3_vs_d  = s2_vs_q;
        s3_pix_d = s2_vde_q ? mode_pix : {3*CW{1'b0}};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_act_q <= MODE_PASS;
            thr_act_q  <= '0;
            fcnt_q     <= '0;
            s1_vde_q   <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_pix_q   <= '0;
            s1_mode_q  <= MODE_PASS;
            s1_thr_q   <= '0;
            s2_vde_q   <= 1'b0;
            s2_hs_q    <= 1'b0;
            s2_vs_q    <= 1'b0;
            s2_pix_q   <= '0;
            s2_mode_q  <= MODE_PASS;
            s2_thr_q   <= '0;
            s2_y_q     <= '0;
            s3_vde_q   <= 1'b0;
            s3_hs_q    <= 1'b0;
            s3_vs_q    <= 1'b0;
            s3_pix_q   <= '0;
        end else begin
            mode_act_q <= mode_act_d;
            thr_act_q  <= thr_act_d;
            fcnt_q     <= fcnt_d;
            s1_vde_q   <= s1_vde_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_pix_q   <= s1_pix_d;
            s1_mode_q  <= s1_mode_d;
            s1_thr_q   <= s1_thr_d;
            s2_vde_q   <= s2_vde_d;
            s2_hs_q    <= s2_hs_d;
            s2_vs_q    <= s2_vs_d;
            s2_pix_q   <= s2_pix_d;
            s2_mode_q  <= s2_mode_d;
            s2_thr_q   <= s2_thr_d;
            s2_y_q     <= s2_y_d;
            s3_vde_q   <= s3_vde_d;
            s3_hs_q    <= s3_hs_d;
            s3_vs_q    <= s3_vs_d;
            s3_pix_q   <= s3_pix_d;
        end
    end

    assign o_VDE        = s3_vde_q;
    assign o_HSYNC      = s3_hs_q;
    assign o_VSYNC      = s3_vs_q;
    assign o_pixelData  = s3_pix_q;
    assign o_modeActive = mode_act_q;
    assign o_frameCnt   = fcnt_q;

endmodule

// File: tb/tb_pixel_mode_proc.sv
// tb/tb_pixel_mode_proc.sv - directed self-checking bench for pixel_mode_proc
module tb_pixel_mode_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic        vde, hs, vs;
    logic [23:0] pix;
    logic [1:0]  mode;
    logic [7:0]  thresh;
    logic        o_vde, o_hs, o_vs;
    logic [23:0] o_pix;
    logic [1:0]  o_mode;
    logic [15:0] o_fcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pixel_mode_proc #(.CW(8), .FCNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_VDE        (vde),
        .i_HSYNC      (hs),
        .i_VSYNC      (vs),
        .i_pixelData  (pix),
        .i_mode       (mode),
        .i_thresh     (thresh),
        .o_VDE        (o_vde),
        .o_HSYNC      (o_hs),
        .o_VSYNC      (o_vs),
        .o_pixelData  (o_pix),
        .o_modeActive (o_mode),
        .o_frameCnt   (o_fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle VSYNC pulse during blanking, then confirm the delayed pulse and new mode
    task automatic frame(input logic [1:0] m, input logic [7:0] t);
        mode   = m;
        thresh = t;
        vde    = 1'b0;
        vs     = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("vsync_delayed", o_vs, 1);
        @(negedge clk);
        chk("vsync_one_cycle", o_vs, 0);
        chk("mode_active", o_mode, m);
    endtask

    task automatic px(input string tag, input logic [23:0] p, input logic [23:0] exp);
        vde = 1'b1;
        pix = p;
        repeat (3) @(negedge clk);
        chk(tag, o_pix, exp);
        chk("vde_aligned", o_vde, 1);
    endtask

    initial begin
        rst = 1'b1; vde = 1'b0; hs = 1'b0; vs = 1'b0;
        pix = 24'h0; mode = 2'd0; thresh = 8'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pix", o_pix, 0);
        chk("rst_vde", o_vde, 0);
        chk("rst_mode", o_mode, 0);
        chk("rst_fcnt", o_fcnt, 0);
        rst = 1'b0;

        // pass mode with sync alignment
        vde = 1'b1; hs = 1'b1; pix = 24'h123456;
        @(negedge clk);
        @(negedge clk);
        chk("vde_not_early", o_vde, 0);
        chk("hs_not_early", o_hs, 0);
        @(negedge clk);
        chk("pass_pix", o_pix, 24'h123456);
        chk("pass_vde", o_vde, 1);
        chk("pass_hs", o_hs, 1);
        chk("pass_vs", o_vs, 0);
        hs = 1'b0;

        // invert
        frame(2'd1, 8'h00);
        chk("fcnt_1", o_fcnt, 1);
        px("invert", 24'h00FF80, 24'hFF007F);

        // gray: 77*255 = 19635, >>8 = 76
        frame(2'd2, 8'h00);
        chk("fcnt_2", o_fcnt, 2);
        px("gray_white", 24'hFFFFFF, 24'hFFFFFF);
        px("gray_red", 24'hFF0000, 24'h4C4C4C);

        // binary
        frame(2'd3, 8'h80);
        px("bin_at_thresh", 24'h808080, 24'hFFFFFF);
        px("bin_below", 24'h7F7F7F, 24'h000000);
        frame(2'd3, 8'h00);
        chk("fcnt_4", o_fcnt, 4);
        px("bin_thresh0", 24'h000000, 24'hFFFFFF);

        // mid-frame mode request is ignored
        mode = 2'd0;
        px("midframe_ignored", 24'h123456, 24'hFFFFFF);
        chk("midframe_mode", o_mode, 3);

        // switch at VSYNC rise with pixels in flight; VSYNC held two cycles
        mode = 2'd1;
        vde = 1'b1; pix = 24'h123456; vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("inflight_before", o_pix, 24'hFFFFFF);
        vs = 1'b0;
        @(negedge clk);
        chk("inflight_rise", o_pix, 24'hFFFFFF);
        @(negedge clk);
        chk("after_rise", o_pix, 24'hEDCBA9);
        chk("fcnt_held_vs", o_fcnt, 5);
        chk("mode_switched", o_mode, 1);

        // blanking
        vde = 1'b0; pix = 24'hABCDEF;
        repeat (3) @(negedge clk);
        chk("blank_pix", o_pix, 0);
        chk("blank_vde", o_vde, 0);

        // reset mid-frame
        px("pre_reset", 24'hABCDEF, 24'h543210);
        rst = 1'b1;
        #1;
        chk("rst_async_pix", o_pix, 0);
        chk("rst_async_vde", o_vde, 0);
        chk("rst_async_mode", o_mode, 0);
        chk("rst_async_fcnt", o_fcnt, 0);
        @(negedge clk);
        rst = 1'b0;
        px("post_reset_pass", 24'hABCDEF, 24'hABCDEF);
        chk("post_reset_mode", o_mode, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
